// File: rtl/seven_segment_scanner_pkg.sv
// seven_segment_scanner_pkg: glyph table, blank glyph and active-low helper
package seven_segment_scanner_pkg;
  localparam logic [6:0] BLANK_GLYPH = 7'h00;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] active_low(input logic [6:0] p);
    return ~p;
  endfunction
endpackage

// File: rtl/seven_segment_scanner_segment_glyph_decoder.sv
// segment_glyph_decoder: nibble to active-low segment pattern, hex letters optional
module segment_glyph_decoder
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg_n
);
  assign seg_n = active_low((blank || (!hex_mode && nibble > 4'd9)) ? BLANK_GLYPH : GLYPHS[nibble]);
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed common-anode driver with frame-synchronous updates
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int HEX_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_leading,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);
  localparam int PW  = $clog2(SCAN_DIV);
  localparam int IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VIS = SCAN_DIV - BLANK_CYCLES;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_value, act_value;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp, lz;
  logic                    sh_bl, act_bl, pending;
  logic                    slot_wrap, frame_wrap, visible, suppress, z;
  logic [3:0]              nib;
  logic [6:0]              glyph_n;
  always_comb begin
    slot_wrap  = pre == PW'(SCAN_DIV - 1);
    frame_wrap = slot_wrap && idx == IW'(NUM_DIGITS - 1);
    visible    = 32'(pre) < VIS;
    nib        = 4'(act_value >> {idx, 2'b00});
    z          = 1'b1;
    lz         = '0;
    // lz[i] is set when digit i and every digit above it are zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z     = z && act_value[4*i +: 4] == 4'd0;
      lz[i] = z;
    end
    suppress = act_bl && idx != '0 && lz[idx];
  end
  segment_glyph_decoder u_glyph (
    .nibble  (nib),
    .hex_mode(HEX_MODE != 0),
    .blank   (suppress),
    .seg_n   (glyph_n)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_bl      <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_bl     <= 1'b0;
      segments   <= 7'h7F;
      dp_n       <= 1'b1;
      digit_en_n <= '1;
      frame_done <= 1'b0;
    end else begin
      pre <= slot_wrap ? '0 : pre + 1'b1;
      if (slot_wrap) idx <= frame_wrap ? '0 : idx + 1'b1;
      // a load landing on the wrap bypasses the shadow so it shows this frame
      if (load && frame_wrap) begin
        act_value <= value;
        act_dp    <= dp_in;
        act_bl    <= blank_leading;
        pending   <= 1'b0;
      end else if (load) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_bl    <= blank_leading;
        pending  <= 1'b1;
      end else if (frame_wrap && pending) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_bl    <= sh_bl;
        pending   <= 1'b0;
      end
      frame_done <= frame_wrap;
      segments   <= visible ? glyph_n : 7'h7F;
      dp_n       <= !(visible && act_dp[idx]);
      digit_en_n <= visible ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end
endmodule
